sr_reg_arbiter: RTL

- Round-robin arbiter and sequencer that lets two requesters share one WIDTH-bit register built from set/reset flip-flop bit cells.
- Each requester issues one operation at a time: load, set-mask, clear-mask or no-op.
- The block captures the winning operation, drives the per-bit d/S/R/enable lines, then returns a one-cycle acknowledge.
- Sits between bus-side requesters and the shared control/status register.

---
 rtl/sr_reg_pkg.sv | 17 +
 rtl/sr_reg_bit.sv | 28 ++
 rtl/sr_reg_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sr_reg_pkg.sv
// Shared opcodes and FSM states for the two-requester set/reset register arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sr_reg_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_ACK  = 2'b10
    } state_t;

endpackage

// File: rtl/sr_reg_bit.sv
// Single set/reset register bit cell, priority R > S > en, otherwise hold.
// Latency: Q updates on the clock edge after the control lines are driven.
// Backpressure: none; the cell accepts every cycle.
module sr_reg_bit #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    input  logic S,
    input  logic R,
    input  logic en,
    output logic Q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q <= RST_BIT;
        end else if (R) begin
            Q <= 1'b0;
        end else if (S) begin
            Q <= 1'b1;
        end else if (en) begin
            Q <= d;
        end
    end

endmodule

// File: rtl/sr_reg_arbiter.sv
// Round-robin arbiter sharing one set/reset register between two requesters (ARB_LOCK_EN adds lock0/lock1 re-grant).
// Latency: grant at sample edge, q updated one edge later, ack pulsed for one cycle; 3 cycles per operation.
// Backpressure: losing requester holds req until granted; no timeout, no abort once granted.
import sr_reg_pkg::*;

module sr_reg_arbiter #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] data1,
`ifdef ARB_LOCK_EN
    input  logic             lock0,
    input  logic             lock1,
`endif
    output logic [WIDTH-1:0] q,
    output logic [1:0]       gnt,
    output logic             ack0,
    output logic             ack1,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [1:0]       hop_q, hop_d;
    logic [WIDTH-1:0] hdat_q, hdat_d;
    logic             lock_act;
    logic             grant;
    logic             win;
    logic             exec;
    logic             bit_en;
    logic [WIDTH-1:0] bit_d, bit_s, bit_r;

`ifdef ARB_LOCK_EN
    // Lock is sampled from the current owner in ACK and only honoured in the very next IDLE cycle.
    logic lock_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else if (state_q == ST_ACK) begin
            lock_q <= last_q ? lock1 : lock0;
        end else if (state_q == ST_IDLE) begin
            lock_q <= 1'b0;
        end
    end

    assign lock_act = lock_q & (last_q ? req1 : req0);
`else
    assign lock_act = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            hop_q   <= OP_NOP;
            hdat_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            hop_q   <= hop_d;
            hdat_q  <= hdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        hop_d   = hop_q;
        hdat_d  = hdat_q;
        grant   = 1'b0;
        win     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lock_act) begin
                    grant = 1'b1;
                    win   = last_q;
                end else if (req0 && req1) begin
                    grant = 1'b1;
                    win   = ~last_q;
                end else if (req0) begin
                    grant = 1'b1;
                    win   = 1'b0;
                end else if (req1) begin
                    grant = 1'b1;
                    win   = 1'b1;
                end
                if (grant) begin
                    state_d = ST_EXEC;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    last_d  = win;
                    hop_d   = win ? op1 : op0;
                    hdat_d  = win ? data1 : data0;
                end
            end
            ST_EXEC: begin
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // Cell control lines are only live in EXEC, so q moves exactly at the EXEC->ACK edge.
    assign exec   = (state_q == ST_EXEC);
    assign bit_en = exec && (hop_q == OP_LOAD);
    assign bit_d  = hdat_q;
    assign bit_s  = (exec && (hop_q == OP_SET)) ? hdat_q : '0;
    assign bit_r  = (exec && (hop_q == OP_CLR)) ? hdat_q : '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sr_reg_bit #(
            .RST_BIT(RESET_VAL[i])
        ) u_bit (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (bit_d[i]),
            .S    (bit_s[i]),
            .R    (bit_r[i]),
            .en   (bit_en),
            .Q    (q[i])
        );
    end

    assign gnt  = gnt_q;
    assign ack0 = (state_q == ST_ACK) && gnt_q[0];
    assign ack1 = (state_q == ST_ACK) && gnt_q[1];
    assign busy = (state_q != ST_IDLE);

endmodule
